gerenciar_ativo: RTL

GERENCIAR_ATIVO -- requirements
Module: gerenciar_ativo

---
 rtl/gerenciar_ativo_pkg.sv | 15 +
 rtl/gerenciar_ativo_codificar_prioridade.sv | 22 ++
 rtl/gerenciar_ativo.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gerenciar_ativo_pkg.sv
// Shared definitions for the active-node set manager: defaults and FSM encoding.
package gerenciar_ativo_pkg;

    localparam int unsigned NUM_NA_DEF         = 8;
    localparam int unsigned ADDR_WIDTH_DEF     = 8;
    localparam int unsigned CRITERIO_WIDTH_DEF = 5;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        ATUALIZAR  = 2'd1,
        ESPERAR    = 2'd2,
        SELECIONAR = 2'd3
    } estado_t;

endpackage : gerenciar_ativo_pkg

// File: rtl/gerenciar_ativo_codificar_prioridade.sv
// Lowest-index priority encoder: index of the first set request bit.
module codificar_prioridade #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule : codificar_prioridade

// File: rtl/gerenciar_ativo.sv
// Active-node set manager: holds up to NUM_NA (address, criterion) slots and
// removes the best one by handshaking with an external minimum classifier.
module gerenciar_ativo
    import gerenciar_ativo_pkg::*;
#(
    parameter int unsigned NUM_NA         = NUM_NA_DEF,
    parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int unsigned CRITERIO_WIDTH = CRITERIO_WIDTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             ins_valid_in,
    input  logic [ADDR_WIDTH-1:0]            ins_addr_in,
    input  logic [CRITERIO_WIDTH-1:0]        ins_criterio_in,
    output logic                             ins_ready_o,
    input  logic                             rem_req_in,
    output logic                             rem_valid_o,
    output logic [ADDR_WIDTH-1:0]            rem_addr_o,
    output logic                             rem_vazio_o,
    output logic                             aa_atualizar_o,
    output logic [NUM_NA-1:0]                na_ativo_o,
    output logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_o,
    input  logic                             ca_pronto_in,
    input  logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in,
    output logic                             ocupado_o,
    output logic                             cheio_o,
    output logic                             vazio_o
);

    localparam int unsigned IDX_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;

    estado_t                   state_q, state_d;
    logic [NUM_NA-1:0]         ativo_q, ativo_d;
    logic [CRITERIO_WIDTH-1:0] crit_q [NUM_NA];
    logic [CRITERIO_WIDTH-1:0] crit_d [NUM_NA];
    logic [ADDR_WIDTH-1:0]     addr_q [NUM_NA];
    logic [ADDR_WIDTH-1:0]     addr_d [NUM_NA];
    logic [ADDR_WIDTH-1:0]     rem_addr_q, rem_addr_d;
    logic                      rem_valid_q, rem_valid_d;
    logic                      rem_vazio_q, rem_vazio_d;
    logic                      aa_q, aa_d;

    logic [NUM_NA-1:0] hit_vec, livre_vec, melhor_vec;
    logic [IDX_W-1:0]  livre_idx, melhor_idx;
    logic              livre_valid, melhor_valid;
    logic              ins_ok;

    // Per-slot match vectors: address hit, free slot, and slot holding the minimum.
    always_comb begin
        hit_vec    = '0;
        livre_vec  = '0;
        melhor_vec = '0;
        for (int i = 0; i < int'(NUM_NA); i++) begin
            hit_vec[i]    = ativo_q[i] && (addr_q[i] == ins_addr_in);
            livre_vec[i]  = !ativo_q[i];
            melhor_vec[i] = ativo_q[i] && (crit_q[i] == ca_criterio_geral_in);
        end
    end

    codificar_prioridade #(.N(NUM_NA), .IDX_W(IDX_W)) u_livre (
        .req_i   (livre_vec),
        .idx_o   (livre_idx),
        .valid_o (livre_valid)
    );

    codificar_prioridade #(.N(NUM_NA), .IDX_W(IDX_W)) u_melhor (
        .req_i   (melhor_vec),
        .idx_o   (melhor_idx),
        .valid_o (melhor_valid)
    );

    assign vazio_o     = ~|ativo_q;
    assign cheio_o     = &ativo_q;
    assign ocupado_o   = (state_q != OCIOSO);
    assign ins_ready_o = (state_q == OCIOSO) && !cheio_o;
    assign ins_ok      = ins_valid_in && ins_ready_o;

    // Next-state: insert handling, FSM transitions and removal of the best slot.
    always_comb begin
        state_d     = state_q;
        ativo_d     = ativo_q;
        crit_d      = crit_q;
        addr_d      = addr_q;
        rem_addr_d  = rem_addr_q;
        rem_valid_d = 1'b0;
        rem_vazio_d = 1'b0;
        aa_d        = 1'b0;

        if (ins_ok) begin
            if (|hit_vec) begin
                for (int i = 0; i < int'(NUM_NA); i++) begin
                    if (hit_vec[i] && (ins_criterio_in < crit_q[i])) begin
                        crit_d[i] = ins_criterio_in;
                    end
                end
            end else if (livre_valid) begin
                ativo_d[livre_idx] = 1'b1;
                crit_d[livre_idx]  = ins_criterio_in;
                addr_d[livre_idx]  = ins_addr_in;
            end
        end

        case (state_q)
            OCIOSO: begin
                // A same-cycle insert always lands, so the set is non-empty afterwards.
                if (rem_req_in) begin
                    if (!vazio_o || ins_ok) begin
                        state_d = ATUALIZAR;
                        aa_d    = 1'b1;
                    end else begin
                        rem_vazio_d = 1'b1;
                    end
                end
            end
            ATUALIZAR: state_d = ESPERAR;
            ESPERAR: begin
                if (ca_pronto_in) begin
                    state_d = SELECIONAR;
                end
            end
            SELECIONAR: begin
                state_d = OCIOSO;
                if (melhor_valid) begin
                    rem_valid_d         = 1'b1;
                    rem_addr_d          = addr_q[melhor_idx];
                    ativo_d[melhor_idx] = 1'b0;
                    crit_d[melhor_idx]  = '1;
                end else begin
                    rem_vazio_d = 1'b1;
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    // State and slot registers; inactive slots always hold an all-ones criterion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OCIOSO;
            ativo_q     <= '0;
            rem_addr_q  <= '0;
            rem_valid_q <= 1'b0;
            rem_vazio_q <= 1'b0;
            aa_q        <= 1'b0;
            for (int i = 0; i < int'(NUM_NA); i++) begin
                crit_q[i] <= '1;
                addr_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ativo_q     <= ativo_d;
            crit_q      <= crit_d;
            addr_q      <= addr_d;
            rem_addr_q  <= rem_addr_d;
            rem_valid_q <= rem_valid_d;
            rem_vazio_q <= rem_vazio_d;
            aa_q        <= aa_d;
        end
    end

    // Flatten slot criteria onto the classifier bus.
    always_comb begin
        na_criterio_o = '0;
        for (int i = 0; i < int'(NUM_NA); i++) begin
            na_criterio_o[CRITERIO_WIDTH*i +: CRITERIO_WIDTH] = crit_q[i];
        end
    end

    assign na_ativo_o     = ativo_q;
    assign rem_addr_o     = rem_addr_q;
    assign rem_valid_o    = rem_valid_q;
    assign rem_vazio_o    = rem_vazio_q;
    assign aa_atualizar_o = aa_q;

endmodule : gerenciar_ativo
